// File: rtl/mips_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// No logic here; consumed by mem_arbiter and its testbench.
// Backpressure: not applicable.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned LATENCY_DEF    = 2;
    localparam int unsigned STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signal bundle shared by the arbiter and its users.
// No logic or latency of its own.
// Backpressure: requesters hold req until their ready pulse (or an abort for fetch).
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_abort;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall_f;
    logic        stall_m;

    modport slave (
        input  if_req, if_addr, if_abort, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output if_req, if_addr, if_abort, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// Loadable 3-bit down-counter with zero flag, used to time the memory read latency.
// Load takes effect on the next edge; decrement stops at zero.
// Backpressure: none.
module wait_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);
    logic [2:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_zero = (r_cnt == 3'd0);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, data-priority with starvation guard.
// Request-to-ready LATENCY+2 cycles; one transaction in flight, one IDLE cycle between grants.
// Backpressure: losing requester holds req (stall_f/stall_m high) until its ready pulse.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned LATENCY    = LATENCY_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned   SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [2:0]    WAIT_LOAD  = 3'(LATENCY - 1);

    state_e        r_state;
    owner_e        r_owner;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_if_buf;
    logic [31:0]   r_dm_rdata;
    logic          r_aborted;
    logic [SW-1:0] r_starve_cnt;

    logic w_in_idle;
    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;
    logic w_wait_zero;
    logic w_done;
    logic w_if_ok;

    assign w_in_idle = (r_state == ST_IDLE);
    assign w_starved = bus.if_req & (r_starve_cnt == STARVE_LIM);
    assign w_grant_i = w_in_idle & bus.if_req & ~bus.if_abort & (~bus.dm_req | w_starved);
    assign w_grant_d = w_in_idle & bus.dm_req & ~w_grant_i;
    assign w_done    = (r_state == ST_DONE);
    // An abort arriving in the DONE cycle itself must still kill the fetch result.
    assign w_if_ok   = ~r_aborted & ~bus.if_abort;

    wait_timer u_wait_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (r_state == ST_ISSUE),
        .i_load_val (WAIT_LOAD),
        .i_dec      (r_state == ST_WAIT),
        .o_zero     (w_wait_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_if_rdata   <= 32'd0;
            r_if_buf     <= 32'd0;
            r_dm_rdata   <= 32'd0;
            r_aborted    <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            if (!w_in_idle && (r_owner == OWN_I) && bus.if_abort) begin
                r_aborted <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_i || w_grant_d) begin
                        r_state     <= ST_ISSUE;
                        r_owner     <= w_grant_i ? OWN_I : OWN_D;
                        r_mem_addr  <= w_grant_i ? bus.if_addr : bus.dm_addr;
                        r_mem_wdata <= w_grant_i ? 32'd0 : bus.dm_wdata;
                        r_mem_we    <= w_grant_d & bus.dm_we;
                        r_aborted   <= 1'b0;
                    end
                    if (w_grant_d && bus.if_req) begin
                        if (r_starve_cnt != STARVE_LIM) begin
                            r_starve_cnt <= r_starve_cnt + SW'(1);
                        end
                    end else if (w_grant_i || w_grant_d) begin
                        r_starve_cnt <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_wait_zero) begin
                        r_state <= ST_DONE;
                        if (r_owner == OWN_D && !r_mem_we) begin
                            r_dm_rdata <= bus.mem_rdata;
                        end
                        if (r_owner == OWN_I) begin
                            r_if_buf <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    if (r_owner == OWN_I && w_if_ok) begin
                        r_if_rdata <= r_if_buf;
                    end
                end
            endcase
        end
    end

    assign bus.mem_en    = (r_state == ST_ISSUE);
    assign bus.mem_we    = (r_state == ST_ISSUE) & r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    assign bus.dm_ready  = w_done & (r_owner == OWN_D);
    assign bus.if_ready  = w_done & (r_owner == OWN_I) & w_if_ok;
    // Fetch data is shown from the staging buffer during the ready pulse and committed after it.
    assign bus.if_rdata  = bus.if_ready ? r_if_buf : r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;

    assign bus.stall_f   = bus.if_req & ~bus.if_ready & ~bus.if_abort;
    assign bus.stall_m   = bus.dm_req & ~bus.dm_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model (grant cycle G, issue G+1, ready G+LAT+2).
module tb_mem_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 3;
    localparam int HN   = 8192;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Memory read data: random every cycle unless a directed test pins a cycle.
    logic [31:0] rd_hist [0:HN-1];
    int          ovr_cyc = -1;
    logic [31:0] ovr_val = 32'd0;
    always @(posedge clk) begin
        #1;
        bus.mem_rdata = (cyc == ovr_cyc) ? ovr_val : $urandom;
        rd_hist[cyc % HN] = bus.mem_rdata;
    end

    // Transaction-level reference model.
    bit          m_active = 0;
    int          m_g      = 0;
    bit          m_own_i  = 0;
    bit          m_we     = 0;
    bit          m_abt    = 0;
    logic [31:0] m_addr   = 0;
    logic [31:0] m_wdata  = 0;
    int          m_starve = 0;
    logic [31:0] e_if_rd  = 0;
    logic [31:0] e_dm_rd  = 0;
    bit idle_now, e_en, done, e_ifr, e_dmr, gi, gd;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_active = 0; m_starve = 0; e_if_rd = 0; e_dm_rd = 0;
            chk("rst_mem_en", 32'(bus.mem_en), 0);
            chk("rst_mem_we", 32'(bus.mem_we), 0);
            chk("rst_if_ready", 32'(bus.if_ready), 0);
            chk("rst_dm_ready", 32'(bus.dm_ready), 0);
            chk("rst_if_rdata", bus.if_rdata, 0);
            chk("rst_dm_rdata", bus.dm_rdata, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
        end else begin
            idle_now = !m_active;
            if (m_active && m_own_i && bus.if_abort && cyc > m_g) m_abt = 1;
            e_en  = m_active && (cyc == m_g + 1);
            done  = m_active && (cyc == m_g + LAT + 2);
            e_dmr = done && !m_own_i;
            e_ifr = done && m_own_i && !m_abt;
            if (e_dmr && !m_we) e_dm_rd = rd_hist[(m_g + 1 + LAT) % HN];
            if (e_ifr)          e_if_rd = rd_hist[(m_g + 1 + LAT) % HN];
            chk("mem_en", 32'(bus.mem_en), 32'(e_en));
            chk("mem_we", 32'(bus.mem_we), 32'(e_en && m_we));
            chk("dm_ready", 32'(bus.dm_ready), 32'(e_dmr));
            chk("if_ready", 32'(bus.if_ready), 32'(e_ifr));
            chk("dm_rdata", bus.dm_rdata, e_dm_rd);
            chk("if_rdata", bus.if_rdata, e_if_rd);
            chk("stall_f", 32'(bus.stall_f), 32'(bus.if_req && !e_ifr && !bus.if_abort));
            chk("stall_m", 32'(bus.stall_m), 32'(bus.dm_req && !e_dmr));
            if (e_en) chk("mem_addr", bus.mem_addr, m_addr);
            if (e_en && !m_own_i) chk("mem_wdata", bus.mem_wdata, m_wdata);
            if (done) m_active = 0;
            if (idle_now) begin
                gi = bus.if_req && !bus.if_abort && (!bus.dm_req || (m_starve == SMAX));
                gd = bus.dm_req && !gi;
                if (gi) m_starve = 0;
                if (gd) m_starve = bus.if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
                if (gi || gd) begin
                    m_active = 1; m_g = cyc; m_own_i = gi; m_abt = 0;
                    m_addr  = gi ? bus.if_addr : bus.dm_addr;
                    m_we    = gd && bus.dm_we;
                    m_wdata = bus.dm_wdata;
                end
            end
        end
    end

    task automatic at_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic drv_at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    int  b;
    bit  sif, sdm, last_abt;

    initial begin
        reset_n = 1'b0;
        bus.if_req = 0; bus.if_addr = 0; bus.if_abort = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        at_neg(2);
        chk("reset_mem_en", 32'(bus.mem_en), 0);
        chk("reset_ready", 32'({bus.if_ready, bus.dm_ready}), 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_rdata", bus.if_rdata | bus.dm_rdata, 0);
        drv_at(4);
        reset_n = 1'b1;

        // Single load, LATENCY=2.
        drv_at(cyc + 2); b = cyc;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h40;
        ovr_cyc = b + 3; ovr_val = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            at_neg(b + i);
            chk("t1_stall_m", 32'(bus.stall_m), 1);
            if (i == 1) begin
                chk("t1_mem_en", 32'(bus.mem_en), 1);
                chk("t1_mem_addr", bus.mem_addr, 32'h40);
            end
        end
        at_neg(b + 4);
        chk("t1_dm_ready", 32'(bus.dm_ready), 1);
        chk("t1_dm_rdata", bus.dm_rdata, 32'h1234);
        chk("t1_stall_m_done", 32'(bus.stall_m), 0);
        drv_at(b + 5); bus.dm_req = 0;

        // Store leaves dm_rdata alone.
        drv_at(cyc + 1); b = cyc;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'hDEAD;
        at_neg(b + 1);
        chk("t5_mem_en", 32'(bus.mem_en), 1);
        chk("t5_mem_we", 32'(bus.mem_we), 1);
        chk("t5_mem_addr", bus.mem_addr, 32'h80);
        chk("t5_mem_wdata", bus.mem_wdata, 32'hDEAD);
        at_neg(b + 2);
        chk("t5_mem_we_off", 32'(bus.mem_we), 0);
        at_neg(b + 4);
        chk("t5_dm_ready", 32'(bus.dm_ready), 1);
        chk("t5_dm_rdata", bus.dm_rdata, 32'h1234);
        drv_at(b + 5); bus.dm_req = 0; bus.dm_we = 0;

        // Simultaneous requests: data first, then fetch.
        drv_at(cyc + 1); b = cyc;
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.dm_req = 1; bus.dm_addr = 32'h48;
        at_neg(b + 4);
        chk("t2_dm_ready", 32'(bus.dm_ready), 1);
        chk("t2_if_ready_early", 32'(bus.if_ready), 0);
        drv_at(b + 5); bus.dm_req = 0;
        at_neg(b + 5);
        chk("t2_stall_f", 32'(bus.stall_f), 1);
        at_neg(b + 6);
        chk("t2_if_mem_en", 32'(bus.mem_en), 1);
        chk("t2_if_mem_addr", bus.mem_addr, 32'h100);
        at_neg(b + 9);
        chk("t2_if_ready", 32'(bus.if_ready), 1);
        drv_at(b + 10); bus.if_req = 0;

        // Starvation guard: fourth grant goes to fetch.
        drv_at(cyc + 1); b = cyc;
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.dm_req = 1; bus.dm_addr = 32'h4C;
        ovr_cyc = b + 18; ovr_val = 32'hCAFE0003;
        for (int k = 0; k < 3; k++) begin
            at_neg(b + 5 * k + 1);
            chk("t3_d_addr", bus.mem_addr, 32'h4C);
            at_neg(b + 5 * k + 4);
            chk("t3_dm_ready", 32'(bus.dm_ready), 1);
        end
        at_neg(b + 16);
        chk("t3_if_mem_en", 32'(bus.mem_en), 1);
        chk("t3_if_mem_addr", bus.mem_addr, 32'h200);
        at_neg(b + 19);
        chk("t3_if_ready", 32'(bus.if_ready), 1);
        chk("t3_if_rdata", bus.if_rdata, 32'hCAFE0003);
        drv_at(b + 20); bus.if_req = 0; bus.dm_req = 0;

        // Abort in WAIT: memory access still happens, no ready, if_rdata held.
        drv_at(cyc + 1); b = cyc;
        bus.if_req = 1; bus.if_addr = 32'h300;
        ovr_cyc = b + 3; ovr_val = 32'hBAD0BAD0;
        at_neg(b + 1);
        chk("t4_mem_en", 32'(bus.mem_en), 1);
        drv_at(b + 2); bus.if_abort = 1;
        at_neg(b + 2);
        chk("t4_mem_en_once", 32'(bus.mem_en), 0);
        chk("t4_stall_f", 32'(bus.stall_f), 0);
        drv_at(b + 3); bus.if_abort = 0; bus.if_req = 0;
        at_neg(b + 4);
        chk("t4_if_ready", 32'(bus.if_ready), 0);
        chk("t4_if_rdata", bus.if_rdata, 32'hCAFE0003);
        at_neg(b + 5);
        chk("t4_if_rdata_hold", bus.if_rdata, 32'hCAFE0003);

        // Reset during WAIT.
        drv_at(cyc + 1); b = cyc;
        bus.dm_req = 1; bus.dm_addr = 32'h50;
        drv_at(b + 2);
        reset_n = 0; bus.dm_req = 0;
        #1;
        chk("t6_mem_addr", bus.mem_addr, 0);
        chk("t6_mem_wdata", bus.mem_wdata, 0);
        chk("t6_dm_rdata", bus.dm_rdata, 0);
        chk("t6_if_rdata", bus.if_rdata, 0);
        chk("t6_flags", 32'({bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready}), 0);
        drv_at(b + 4); reset_n = 1;
        for (int i = 4; i < 8; i++) begin
            at_neg(b + i);
            chk("t6_no_ready", 32'(bus.dm_ready), 0);
        end
        drv_at(b + 8);
        bus.dm_req = 1; bus.dm_addr = 32'h44;
        ovr_cyc = b + 11; ovr_val = 32'h5555AAAA;
        at_neg(b + 9);
        chk("t6_mem_en", 32'(bus.mem_en), 1);
        at_neg(b + 12);
        chk("t6_dm_ready", 32'(bus.dm_ready), 1);
        chk("t6_dm_rdata", bus.dm_rdata, 32'h5555AAAA);
        drv_at(b + 13); bus.dm_req = 0;

        // Randomized traffic.
        last_abt = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            sif = bus.if_ready;
            sdm = bus.dm_ready;
            @(posedge clk);
            #1;
            if (bus.if_req && (sif || last_abt)) begin
                bus.if_req = 0;
            end else if (!bus.if_req && $urandom_range(0, 3) == 0) begin
                bus.if_req  = 1;
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            bus.if_abort = ($urandom_range(0, 15) == 0);
            last_abt = bus.if_abort && bus.if_req;
            if (bus.dm_req && sdm) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.dm_req = 0;
                end else begin
                    bus.dm_we = $urandom_range(0, 1) == 1;
                    bus.dm_addr = $urandom & 32'hFFFF_FFFC;
                    bus.dm_wdata = $urandom;
                end
            end else if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
                bus.dm_req = 1;
                bus.dm_we = $urandom_range(0, 1) == 1;
                bus.dm_addr = $urandom & 32'hFFFF_FFFC;
                bus.dm_wdata = $urandom;
            end
        end
        bus.if_req = 0; bus.dm_req = 0; bus.if_abort = 0;
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
